// File: rtl/alu_iter.sv
// alu_iter: clocked ALU with one-cycle arithmetic/logic ops and iterative
// N-cycle signed/unsigned multiply and restoring divide (hi/lo results).
`default_nettype none

module alu_iter #(
  parameter int N = 32
) (
  input  logic         input_clk,
  input  logic         input_reset,
  input  logic         input_start,
  input  logic [3:0]   input_op,
  input  logic [N-1:0] input_a,
  input  logic [N-1:0] input_b,
  output logic [N-1:0] out_result,
  output logic [N-1:0] out_result_hi,
  output logic         out_zero,
  output logic         out_overflow,
  output logic         out_div_zero,
  output logic         out_busy,
  output logic         out_done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   acc_hi;
  logic [N-1:0]   acc_lo;
  logic [N-1:0]   operand_m;
  logic [N-1:0]   a_save;
  logic           is_div;
  logic           neg_q;
  logic           neg_r;
  logic           dz_pend;
  logic           ovf_pend;

  // ---------------- one-cycle datapath ----------------
  logic [N-1:0] add_sum;
  logic [N:0]   sub_full;
  logic [N-1:0] sub_diff;
  logic         sub_carry;
  logic         add_ovf;
  logic         sub_ovf;
  logic [N-1:0] one_res;
  logic         one_ovf;
  logic         one_zero;

  assign add_sum   = input_a + input_b;
  assign sub_full  = {1'b0, input_a} + {1'b0, ~input_b} + {{N{1'b0}}, 1'b1};
  assign sub_diff  = sub_full[N-1:0];
  assign sub_carry = sub_full[N];
  assign add_ovf   = (input_a[N-1] == input_b[N-1]) && (add_sum[N-1] != input_a[N-1]);
  assign sub_ovf   = (input_a[N-1] != input_b[N-1]) && (sub_diff[N-1] != input_a[N-1]);

  always_comb begin
    one_res  = '0;
    one_ovf  = 1'b0;
    one_zero = 1'b0;
    case (input_op)
      4'b0000: one_res = add_sum;
      4'b0001: begin one_res = add_sum;  one_ovf = add_ovf; end
      4'b0010: one_res = sub_diff;
      4'b0011: begin one_res = sub_diff; one_ovf = sub_ovf; end
      4'b0100: one_res = input_a | input_b;
      4'b0101: one_res = input_a & input_b;
      4'b0110: one_res = {{(N-1){1'b0}}, sub_diff[N-1] ^ sub_ovf};
      4'b0111: one_res = {{(N-1){1'b0}}, ~sub_carry};
      default: one_res = '0;
    endcase
    // Reserved ops report every flag as 0, including zero.
    one_zero = (input_op[3:2] != 2'b11) && (one_res == '0);
  end

  // ---------------- iterative operand capture ----------------
  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] a_mag;
  logic [N-1:0] b_mag;
  logic         div_min_neg1;

  assign a_neg        = input_op[0] & input_a[N-1];
  assign b_neg        = input_op[0] & input_b[N-1];
  assign a_mag        = a_neg ? (~input_a + {{(N-1){1'b0}}, 1'b1}) : input_a;
  assign b_mag        = b_neg ? (~input_b + {{(N-1){1'b0}}, 1'b1}) : input_b;
  assign div_min_neg1 = (input_op == 4'b1011) && (input_a == {1'b1, {(N-1){1'b0}}})
                        && (input_b == {N{1'b1}});

  // ---------------- one iteration step ----------------
  logic [N:0]     mul_sum;
  logic [N:0]     div_shift;
  logic [N:0]     div_diff;
  logic [N-1:0]   step_hi;
  logic [N-1:0]   step_lo;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_s;
  logic [N-1:0]   fin_lo;
  logic [N-1:0]   fin_hi;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_m} : {(N+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[N-1]};
  assign div_diff  = div_shift - {1'b0, operand_m};

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (is_div) begin
      // Remainder stays below the divisor, so the shifted value fits in N+1 bits.
      if (!div_diff[N]) begin
        step_hi = div_diff[N-1:0];
        step_lo = {acc_lo[N-2:0], 1'b1};
      end else begin
        step_hi = div_shift[N-1:0];
        step_lo = {acc_lo[N-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[N:1];
      step_lo = {mul_sum[0], acc_lo[N-1:1]};
    end
  end

  assign prod   = {step_hi, step_lo};
  assign prod_s = neg_q ? (~prod + {{(2*N-1){1'b0}}, 1'b1}) : prod;

  always_comb begin
    fin_lo = prod_s[N-1:0];
    fin_hi = prod_s[2*N-1:N];
    if (is_div) begin
      if (dz_pend) begin
        fin_lo = {N{1'b1}};
        fin_hi = a_save;
      end else begin
        fin_lo = neg_q ? (~step_lo + {{(N-1){1'b0}}, 1'b1}) : step_lo;
        fin_hi = neg_r ? (~step_hi + {{(N-1){1'b0}}, 1'b1}) : step_hi;
      end
    end
  end

  // ---------------- control FSM and result registers ----------------
  always_ff @(posedge input_clk) begin
    if (input_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      operand_m     <= '0;
      a_save        <= '0;
      is_div        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dz_pend       <= 1'b0;
      ovf_pend      <= 1'b0;
      out_result    <= '0;
      out_result_hi <= '0;
      out_zero      <= 1'b0;
      out_overflow  <= 1'b0;
      out_div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (input_start) begin
            if (input_op[3:2] == 2'b10) begin
              state     <= RUN;
              cnt       <= CW'(N);
              acc_hi    <= '0;
              acc_lo    <= input_op[1] ? a_mag : b_mag;
              operand_m <= input_op[1] ? b_mag : a_mag;
              a_save    <= input_a;
              is_div    <= input_op[1];
              neg_q     <= a_neg ^ b_neg;
              neg_r     <= a_neg;
              dz_pend   <= input_op[1] && (input_b == '0);
              ovf_pend  <= div_min_neg1;
            end else begin
              state         <= DONE;
              out_result    <= one_res;
              out_result_hi <= '0;
              out_zero      <= one_zero;
              out_overflow  <= one_ovf;
              out_div_zero  <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state         <= DONE;
            out_result    <= fin_lo;
            out_result_hi <= fin_hi;
            out_zero      <= (fin_lo == '0);
            out_overflow  <= ovf_pend;
            out_div_zero  <= dz_pend;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_busy = (state == RUN);
  assign out_done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter (N=32).
`default_nettype none

module tb_alu_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;
  logic        div_zero;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [3:0] OP_ADDU = 4'b0000, OP_ADD = 4'b0001, OP_SUB = 4'b0011,
                         OP_OR = 4'b0100, OP_SLT = 4'b0110, OP_SLTU = 4'b0111,
                         OP_MULTU = 4'b1000, OP_MULT = 4'b1001, OP_DIVU = 4'b1010,
                         OP_DIV = 4'b1011, OP_RSV = 4'b1100;

  alu_iter #(.N(32)) dut (
    .input_clk     (clk),
    .input_reset   (reset),
    .input_start   (start),
    .input_op      (op),
    .input_a       (a),
    .input_b       (b),
    .out_result    (result),
    .out_result_hi (result_hi),
    .out_zero      (zero),
    .out_overflow  (overflow),
    .out_div_zero  (div_zero),
    .out_busy      (busy),
    .out_done      (done)
  );

  always #5 clk = ~clk;

  // Pulses start for one cycle, then waits (bounded) for done; lat is the
  // cycle index of done counting the accept edge as edge 0.
  task automatic run_op(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({result, result_hi, zero, overflow, div_zero, busy, done} !== 69'd0)
      $display("FAIL reset_state: got res=%h hi=%h z=%b o=%b dz=%b busy=%b done=%b expected all 0",
               result, result_hi, zero, overflow, div_zero, busy, done);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_add_sub();
    int lat, bc;
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat, bc);
    total_cnt++;
    if (lat !== 1) $display("FAIL add_latency: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++;
    if ({result, overflow, zero, result_hi} !== {32'h8000_0000, 1'b1, 1'b0, 32'h0})
      $display("FAIL add_ovf: got res=%h ovf=%b z=%b hi=%h expected 80000000 1 0 0",
               result, overflow, zero, result_hi);
    else pass_cnt++;
    run_op(OP_ADDU, 32'h7FFF_FFFF, 32'h1, lat, bc);
    total_cnt++;
    if ({result, overflow} !== {32'h8000_0000, 1'b0})
      $display("FAIL addu_no_ovf: got res=%h ovf=%b expected 80000000 0", result, overflow);
    else pass_cnt++;
    run_op(OP_SUB, 32'd5, 32'd5, lat, bc);
    total_cnt++;
    if ({result, zero, overflow} !== {32'h0, 1'b1, 1'b0})
      $display("FAIL sub_zero: got res=%h z=%b ovf=%b expected 0 1 0", result, zero, overflow);
    else pass_cnt++;
  endtask

  task automatic test_slt();
    int lat, bc;
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, lat, bc);
    total_cnt++;
    if (result !== 32'h1) $display("FAIL slt: got %h expected 00000001", result); else pass_cnt++;
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1, lat, bc);
    total_cnt++;
    if ({result, zero} !== {32'h0, 1'b1})
      $display("FAIL sltu: got res=%h z=%b expected 0 1", result, zero);
    else pass_cnt++;
  endtask

  task automatic test_mult();
    int lat, bc;
    run_op(OP_MULT, -32'sd3, 32'd7, lat, bc);
    total_cnt++;
    if ({lat, bc} !== {32'd33, 32'd32})
      $display("FAIL mult_timing: got lat=%0d busy=%0d expected 33 32", lat, bc);
    else pass_cnt++;
    total_cnt++;
    if ({result_hi, result, overflow, div_zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 2'b00})
      $display("FAIL mult_neg: got hi=%h lo=%h ovf=%b dz=%b expected ffffffff ffffffeb 0 0",
               result_hi, result, overflow, div_zero);
    else pass_cnt++;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    total_cnt++;
    if ({result_hi, result} !== {32'hFFFF_FFFE, 32'h0000_0001})
      $display("FAIL multu_max: got hi=%h lo=%h expected fffffffe 00000001", result_hi, result);
    else pass_cnt++;
  endtask

  task automatic test_div();
    int lat, bc;
    run_op(OP_DIV, -32'sd7, 32'd2, lat, bc);
    total_cnt++;
    if ({result, result_hi, lat} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd33})
      $display("FAIL div_neg: got q=%h r=%h lat=%0d expected fffffffd ffffffff 33",
               result, result_hi, lat);
    else pass_cnt++;
    run_op(OP_DIVU, 32'd9, 32'd0, lat, bc);
    total_cnt++;
    if ({result, result_hi, div_zero, overflow, lat} !== {32'hFFFF_FFFF, 32'd9, 2'b10, 32'd33})
      $display("FAIL divu_by_zero: got q=%h r=%h dz=%b ovf=%b lat=%0d expected ffffffff 9 1 0 33",
               result, result_hi, div_zero, overflow, lat);
    else pass_cnt++;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    total_cnt++;
    if ({result, result_hi, overflow, div_zero} !== {32'h8000_0000, 32'h0, 2'b10})
      $display("FAIL div_overflow: got q=%h r=%h ovf=%b dz=%b expected 80000000 0 1 0",
               result, result_hi, overflow, div_zero);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 5) begin
        start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    total_cnt++;
    if ({result, result_hi, lat} !== {32'd42, 32'd0, 32'd33})
      $display("FAIL start_in_run: got lo=%h hi=%h lat=%0d expected 0000002a 0 33",
               result, result_hi, lat);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL done_single_pulse: got %b expected 0", done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; op = OP_OR; a = 32'h0000_00F0; b = 32'h0000_000F;
    @(negedge clk);
    total_cnt++;
    if ({done, result} !== {1'b1, 32'h0000_00FF})
      $display("FAIL b2b_first: got done=%b res=%h expected 1 000000ff", done, result);
    else pass_cnt++;
    a = 32'h0000_0100; b = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if ({done, result} !== {1'b1, 32'h0000_0101})
      $display("FAIL b2b_second: got done=%b res=%h expected 1 00000101", done, result);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, result} !== {1'b0, 32'h0000_0101})
      $display("FAIL b2b_hold: got done=%b res=%h expected 0 00000101", done, result);
    else pass_cnt++;
  endtask

  task automatic test_reserved();
    int lat, bc;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    run_op(OP_RSV, 32'd5, 32'd3, lat, bc);
    total_cnt++;
    if ({lat, result, result_hi, zero, overflow, div_zero} !== {32'd1, 64'd0, 3'b000})
      $display("FAIL reserved: got lat=%0d res=%h hi=%h z=%b ovf=%b dz=%b expected 1 0 0 0 0 0",
               lat, result, result_hi, zero, overflow, div_zero);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic seen_done;
    run_op(OP_OR, 32'h55, 32'h0, lat, bc);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_before_reset: got %b expected 1", busy); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if ({result, result_hi, zero, overflow, div_zero, busy, done} !== 69'd0)
      $display("FAIL reset_mid_run: got res=%h hi=%h z=%b o=%b dz=%b busy=%b done=%b expected all 0",
               result, result_hi, zero, overflow, div_zero, busy, done);
    else pass_cnt++;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    total_cnt++;
    if (seen_done !== 1'b0) $display("FAIL aborted_no_done: got activity=%b expected 0", seen_done);
    else pass_cnt++;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc);
    total_cnt++;
    if ({result, result_hi, lat, bc} !== {32'd14, 32'd2, 32'd33, 32'd32})
      $display("FAIL divu_after_reset: got q=%0d r=%0d lat=%0d busy=%0d expected 14 2 33 32",
               result, result_hi, lat, bc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_slt();
    test_mult();
    test_div();
    test_ignore_start();
    test_back_to_back();
    test_reserved();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, clocked successor to the single-cycle datapath ALU.
- Keeps the one-cycle arithmetic and logic operations, with registered results.
- Adds iterative signed and unsigned multiply and divide that take N cycles, with a 64-bit-style hi/lo result pair.
- Sits in the multicycle core's execute stage and is sequenced by the control FSM through a start/busy/done handshake.

Parameters:
- N, 32: operand and result width. Must be >= 4. Iteration counter width is clog2(N+1).

Ports:
- input_clk  in  1  rising-edge clock.
- input_reset  in  1  synchronous, active-high reset.
- input_start  in  1  operation request; sampled only when out_busy=0.
- input_op  in  4  operation select; encoding under Behaviour.
- input_a  in  N  operand A; captured on an accepted start.
- input_b  in  N  operand B; captured on an accepted start.
- out_result  out  N  low result: sum, logic result, product low half, or quotient.
- out_result_hi  out  N  product high half or remainder; 0 for one-cycle ops.
- out_zero  out  1  out_result == 0.
- out_overflow  out  1  signed overflow (add/sub) or signed division overflow.
- out_div_zero  out  1  divisor was zero.
- out_busy  out  1  high in RUN.
- out_done  out  1  one-cycle pulse: results valid.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset clears all outputs and internal state to 0 and forces state IDLE. This includes reset mid-RUN: the operation is aborted and no done pulse is issued.
- op encoding:
  - 0000 addu (no overflow)
  - 0001 add (signed overflow detected)
  - 0010 subu
  - 0011 sub (signed overflow detected)
  - 0100 or
  - 0101 and
  - 0110 slt (signed)
  - 0111 sltu
  - 1000 multu
  - 1001 mult
  - 1010 divu
  - 1011 div
  - 11xx reserved: one-cycle, all results 0, all flags 0.
- States: IDLE, RUN, DONE.
- Start is accepted in IDLE or DONE when input_start=1. Start is ignored in RUN; the in-flight operation is not disturbed.
- One-cycle ops (0000-0111, 11xx):
  - Accept -> DONE on the next edge, with results registered on that same edge.
  - out_done=1 for that one cycle. Latency is 1.
- Iterative ops (1000-1011):
  - Accept -> RUN, counter=N, with operand magnitudes latched. Signed ops take the two's-complement absolute value; the signs are saved.
  - Each RUN cycle does one shift-add step (multiply) or one restoring shift-subtract step (divide), then counter decrements.
  - counter==1 -> DONE, with sign correction and result registration on that edge.
  - Start accepted at edge 0 -> out_busy high for cycles 1..N -> out_done high in cycle N+1. Latency is N+1.
- DONE -> IDLE on the next edge unless a new start is accepted. out_done is 0 outside DONE.
- Results and flags hold their values until the next operation completes; they are not cleared on a new start.
- add/sub:
  - overflow = operand signs equal (after B inversion) and sum sign differs.
  - addu and subu never set out_overflow.
  - out_zero reflects out_result for all ops.
- slt/sltu: result = {N-1 zeros, less}.
  - slt less = sign(a-b) XOR overflow.
  - sltu less = NOT carry-out of a + ~b + 1.
- mult/multu:
  - {out_result_hi, out_result} = 2N-bit product.
  - mult sign = sign(a) XOR sign(b). Negate the 2N-bit magnitude when the sign is 1.
- div/divu:
  - out_result = quotient, truncated toward zero. out_result_hi = remainder, which takes the sign of the dividend.
  - b==0: quotient = all ones, remainder = a, out_div_zero=1, same N+1 latency.
  - div with a = -2^(N-1) and b = -1: quotient = -2^(N-1), remainder = 0, out_overflow=1.
  - Otherwise out_overflow=0 and out_div_zero=0 for mul/div.

Test Plan:
- Reset mid-operation: N=32, start divu a=100 b=7, assert input_reset at cycle 10 -> out_busy=0 next cycle, all outputs 0, no out_done. Then a fresh start works normally.
- One-cycle ops:
  - add a=0x7FFFFFFF b=1 -> done at cycle 1, result 0x80000000, overflow=1.
  - addu with the same operands -> overflow=0.
  - sub a=5 b=5 -> zero=1.
- Comparisons:
  - slt a=0xFFFFFFFF b=1 -> result 1.
  - sltu with the same operands -> result 0.
- Multiply:
  - mult a=-3 b=7 -> busy cycles 1..32, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Divide:
  - div a=-7 b=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - divu a=9 b=0 -> quotient 0xFFFFFFFF, remainder 9, div_zero=1.
  - div a=0x80000000 b=-1 -> quotient 0x80000000, remainder 0, overflow=1.
- Handshake:
  - Start pulsed during RUN -> ignored; the original result is unchanged.
  - Start asserted in the DONE cycle -> accepted; back-to-back or ops give done in consecutive cycles.
  - Reserved op 1100 -> done at cycle 1, all outputs 0.
